seg7_scan_display: RTL

Time-multiplexed 4-digit hexadecimal seven-segment driver. It consumes the 16-bit count produced by the project 3 counter and presents it on a common-anode, active-low 4-digit display. The block snapshots the value once per scan frame so a digit never changes mid-frame, and it supports optional leading-zero blanking. It sits between the counter's output and the board display pins.

---
 rtl/seg7_scan_display.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_display
//  Description : Time-multiplexed 4-digit hexadecimal seven-segment driver for
//                a common-anode, active-low display. The displayed value is
//                snapshotted once per scan frame, and leading zeros can
//                optionally be blanked.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [6:0]  segments,
  output logic [3:0]  digit_en,
  output logic        frame_done
);

  localparam int            PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] C_TERM = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] C_ONE  = PW'(1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [6:0]    segments_q, segments_d;
  logic [3:0]    digit_en_q, digit_en_d;
  logic          frame_done_q, frame_done_d;

  logic [3:0]    nibble_w;
  logic          lz_zero_w;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan sequencing: prescaler/digit advance while enabled; the snapshot tracks
  // the input while disabled and is reloaded only at the frame wrap otherwise.
  always_comb begin
    prescaler_d  = prescaler_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (enable) begin
      if (prescaler_q == C_TERM) begin
        prescaler_d = '0;
        idx_d       = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          snap_d       = value;
          frame_done_d = 1'b1;
        end
      end else begin
        prescaler_d = prescaler_q + C_ONE;
      end
    end else begin
      snap_d = value;
    end
  end

  // Output decode from the post-edge digit index and snapshot, so the anode and
  // segment registers switch on the same edge as the index.
  always_comb begin
    nibble_w  = snap_d[3:0];
    lz_zero_w = 1'b0;
    case (idx_d)
      2'd0: begin
        nibble_w  = snap_d[3:0];
        lz_zero_w = 1'b0;
      end
      2'd1: begin
        nibble_w  = snap_d[7:4];
        lz_zero_w = (snap_d[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_w  = snap_d[11:8];
        lz_zero_w = (snap_d[15:8] == 8'h00);
      end
      default: begin
        nibble_w  = snap_d[15:12];
        lz_zero_w = (snap_d[15:12] == 4'h0);
      end
    endcase

    segments_d = 7'h7F;
    digit_en_d = 4'hF;
    if (enable) begin
      // The anode stays driven for a blanked digit so scan timing is unchanged.
      digit_en_d = ~(4'b0001 << idx_d);
      if (!(blank_lz && lz_zero_w)) begin
        segments_d = hex_to_seg(nibble_w);
      end
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      prescaler_q  <= '0;
      idx_q        <= 2'd0;
      snap_q       <= 16'h0000;
      segments_q   <= 7'h7F;
      digit_en_q   <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      segments_q   <= segments_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments   = segments_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
